seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 92 +++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-configurable serial pattern detector with overlap mode and saturating match counter
module seq_detect_param #(
    parameter int               PAT_W   = 8,
    parameter int               LEN_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0000_1001),
    parameter int               DEF_LEN = 4,
    parameter logic             DEF_OVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             data_in,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pat_value,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             ovl_in,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    localparam logic DEF_ERR = (DEF_LEN < 2) || (DEF_LEN > PAT_W);

    function automatic logic len_bad(input logic [LEN_W-1:0] l);
        return (int'(l) < 2) || (int'(l) > PAT_W);
    endfunction

    logic [PAT_W-2:0] hist;
    logic [LEN_W-1:0] fill;
    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic [LEN_W:0]   fill_p1;
    logic             fill_ok;

    // hist[0] is the most recent bit, so {hist, data_in} lines up with pat_r[len-1:0].
    always_comb begin
        window  = {hist, data_in};
        mask    = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_r));
        end
        fill_p1 = {1'b0, fill} + (LEN_W+1)'(1);
        fill_ok = fill_p1 >= {1'b0, len_r};
        match   = valid_in && !cfg_load && !rst && !cfg_err && fill_ok
                  && (((window ^ pat_r) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            match_q   <= 1'b0;
            pat_r     <= DEF_PAT;
            len_r     <= LEN_W'(DEF_LEN);
            ovl_r     <= DEF_OVL;
            cfg_err   <= DEF_ERR;
        end else if (cfg_load) begin
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            match_q   <= 1'b0;
            pat_r     <= pat_value;
            len_r     <= pat_len;
            ovl_r     <= ovl_in;
            cfg_err   <= len_bad(pat_len);
        end else begin
            match_q <= match;
            if (valid_in) begin
                if (match && !ovl_r) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= (PAT_W-1)'(window);
                    if (int'(fill) < PAT_W-1) begin
                        fill <= fill + LEN_W'(1);
                    end
                end
                if (match && (match_cnt != '1)) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
